exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/reg_file4.sv | 42 ++++
 rtl/exec_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_exec_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the three-phase execution sequencer: opcodes, FSM states
// and the instruction word layout.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_XOR   = 2'd2,
        OP_MOVBR = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    localparam int INSTR_W   = 8;
    localparam int OPC_LSB   = 6;
    localparam int ADDRS_LSB = 2;
    localparam int ADDRS_W   = 4;
    localparam int RD_LSB    = 4;
    localparam int RS_LSB    = 2;
    localparam int RM_LSB    = 0;
    localparam int NUM_REGS  = 4;

    // Field order matches the bit positions above; addrs overlays {rd, rs}.
    typedef struct packed {
        opcode_e    opcode;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rm;
    } instr_t;

    function automatic logic [ADDRS_W-1:0] instr_addrs(input instr_t i);
        return {i.rd, i.rs};
    endfunction

endpackage

// File: rtl/reg_file4.sv
// Four-entry register file: two asynchronous operand read ports, an asynchronous
// debug read port and a single synchronous write port.
module reg_file4
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [1:0]        ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              we,
    input  logic [1:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd0       = regs_q[ra0];
    assign rd1       = regs_q[ra1];
    assign dbg_rdata = regs_q[dbg_sel];

endmodule

// File: rtl/exec_sequencer.sv
// FETCH/EXEC/WB sequencer driving an external ALU: holds pc, flags, the toggle
// pin and the register file, and applies ALU results in the WB phase.
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              fetch_req,
    output logic [PC_W-1:0]   fetch_pc,
    input  logic              fetch_valid,
    input  logic [7:0]        fetch_instr,
    output logic [1:0]        alu_opcode,
    output logic [PC_W-1:0]   alu_addrs,
    output logic [DATA_W-1:0] alu_din0,
    output logic [DATA_W-1:0] alu_din1,
    input  logic [DATA_W-1:0] alu_dout,
    input  logic              alu_carry,
    input  logic              alu_borrow,
    input  logic              alu_bcf,
    input  logic              alu_bbf,
    input  logic              alu_buc,
    input  logic              alu_toggle,
    output logic              toggle_q,
    input  logic              dbg_we,
    input  logic [1:0]        dbg_sel,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    instr_t              instr_q, instr_d;
    logic                carry_q, carry_d;
    logic                borrow_q, borrow_d;
    logic                toggle_d;
    logic [1:0]          alu_opcode_q, alu_opcode_d;
    logic [PC_W-1:0]     alu_addrs_q, alu_addrs_d;
    logic [DATA_W-1:0]   alu_din0_q, alu_din0_d;
    logic [DATA_W-1:0]   alu_din1_q, alu_din1_d;

    instr_t              f_instr;
    logic                fetch_hs;
    logic                br_flag, br_taken;
    logic [1:0]          ra0, ra1;
    logic [DATA_W-1:0]   rd0, rd1;
    logic                rf_we;
    logic [1:0]          rf_wa;
    logic [DATA_W-1:0]   rf_wd;
    logic                unused_instr_rm;

    assign f_instr         = instr_t'(fetch_instr);
    assign fetch_hs        = fetch_req && fetch_valid;
    assign unused_instr_rm = ^instr_q.rm;

    // Operands are read straight from the incoming word so they are stable for all of EXEC and WB.
    assign ra0 = (f_instr.opcode == OP_MOVBR) ? f_instr.rm : f_instr.rd;
    assign ra1 = f_instr.rs;

    assign br_flag  = alu_bcf || alu_bbf || alu_buc;
    assign br_taken = alu_buc || (alu_bcf && carry_q) || (alu_bbf && borrow_q);

    reg_file4 #(.DATA_W(DATA_W)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra0       (ra0),
        .rd0       (rd0),
        .ra1       (ra1),
        .rd1       (rd1),
        .dbg_sel   (dbg_sel),
        .dbg_rdata (dbg_rdata),
        .we        (rf_we),
        .wa        (rf_wa),
        .wd        (rf_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (fetch_hs) state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        fetch_req = rst_n && run && (state_q == ST_FETCH);
        fetch_pc  = pc_q;
    end

    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        carry_d      = carry_q;
        borrow_d     = borrow_q;
        toggle_d     = toggle_q;
        alu_opcode_d = alu_opcode_q;
        alu_addrs_d  = alu_addrs_q;
        alu_din0_d   = alu_din0_q;
        alu_din1_d   = alu_din1_q;
        rf_we        = 1'b0;
        rf_wa        = '0;
        rf_wd        = '0;
        case (state_q)
            ST_FETCH: begin
                if (fetch_hs) begin
                    instr_d      = f_instr;
                    alu_opcode_d = f_instr.opcode;
                    alu_addrs_d  = PC_W'(instr_addrs(f_instr));
                    alu_din0_d   = rd0;
                    alu_din1_d   = (f_instr.opcode == OP_MOVBR) ? '0 : rd1;
                end else if (!run && dbg_we) begin
                    rf_we = 1'b1;
                    rf_wa = dbg_sel;
                    rf_wd = dbg_wdata;
                end
            end
            ST_WB: begin
                toggle_d = toggle_q ^ alu_toggle;
                pc_d     = pc_q + PC_W'(1);
                rf_wa    = instr_q.rd;
                rf_wd    = alu_dout;
                case (instr_q.opcode)
                    OP_ADD: begin
                        rf_we   = 1'b1;
                        carry_d = alu_carry;
                    end
                    OP_SUB: begin
                        rf_we    = 1'b1;
                        borrow_d = alu_borrow;
                    end
                    OP_XOR: rf_we = 1'b1;
                    default: begin
                        // A branch flag suppresses the move even when the branch falls through.
                        if (br_taken) begin
                            pc_d = alu_addrs_q;
                        end else if (!br_flag) begin
                            rf_we = 1'b1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            instr_q      <= '0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
            toggle_q     <= 1'b0;
            alu_opcode_q <= '0;
            alu_addrs_q  <= '0;
            alu_din0_q   <= '0;
            alu_din1_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            carry_q      <= carry_d;
            borrow_q     <= borrow_d;
            toggle_q     <= toggle_d;
            alu_opcode_q <= alu_opcode_d;
            alu_addrs_q  <= alu_addrs_d;
            alu_din0_q   <= alu_din0_d;
            alu_din1_q   <= alu_din1_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_addrs  = alu_addrs_q;
    assign alu_din0   = alu_din0_q;
    assign alu_din1   = alu_din1_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus queues expected fetch addresses and
// observations; a negedge monitor pops and compares them.
module tb_exec_sequencer;

    typedef struct {
        int         kind;   // 0 reg via dbg, 1 toggle_q, 2 fetch_pc, 3 fetch_req
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       fetch_req;
    logic [3:0] fetch_pc;
    logic       fetch_valid = 1'b0;
    logic [7:0] fetch_instr = 8'h00;
    logic [1:0] alu_opcode;
    logic [3:0] alu_addrs;
    logic [7:0] alu_din0, alu_din1, alu_dout;
    logic       alu_carry, alu_borrow;
    logic       b_bcf = 1'b0, b_bbf = 1'b0, b_buc = 1'b0, b_tog = 1'b0;
    logic       toggle_q;
    logic       dbg_we = 1'b0;
    logic [1:0] dbg_sel = 2'd0;
    logic [7:0] dbg_wdata = 8'h00;
    logic [7:0] dbg_rdata;
    logic       obs_en = 1'b0;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] exp_pc_q[$];
    exp_t       obs_q[$];
    logic [3:0] m_pc;
    exp_t       m_e;
    logic [7:0] m_act;

    always #5 clk = ~clk;

    exec_sequencer #(.DATA_W(8), .PC_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .alu_opcode  (alu_opcode),
        .alu_addrs   (alu_addrs),
        .alu_din0    (alu_din0),
        .alu_din1    (alu_din1),
        .alu_dout    (alu_dout),
        .alu_carry   (alu_carry),
        .alu_borrow  (alu_borrow),
        .alu_bcf     (b_bcf),
        .alu_bbf     (b_bbf),
        .alu_buc     (b_buc),
        .alu_toggle  (b_tog),
        .toggle_q    (toggle_q),
        .dbg_we      (dbg_we),
        .dbg_sel     (dbg_sel),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata)
    );

    // External ALU stand-in; branch/toggle strobes come from the stimulus.
    always_comb begin
        alu_dout   = 8'h00;
        alu_carry  = 1'b0;
        alu_borrow = 1'b0;
        case (alu_opcode)
            2'd0: {alu_carry, alu_dout} = {1'b0, alu_din0} + {1'b0, alu_din1};
            2'd1: begin
                alu_dout   = alu_din0 - alu_din1;
                alu_borrow = (alu_din0 < alu_din1);
            end
            2'd2: alu_dout = alu_din0 ^ alu_din1;
            default: alu_dout = alu_din0;
        endcase
    end

    always @(negedge clk) begin
        if (fetch_req && fetch_valid) begin
            n_tests++;
            if (exp_pc_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected got pc=%0h want none", fetch_pc);
            end else begin
                m_pc = exp_pc_q.pop_front();
                if (fetch_pc !== m_pc) begin
                    n_fail++;
                    $display("FAIL fetch_pc got %0h want %0h", fetch_pc, m_pc);
                end
            end
        end
        if (obs_en) begin
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL obs_unexpected got strobe want none");
            end else begin
                m_e = obs_q.pop_front();
                case (m_e.kind)
                    0:       m_act = dbg_rdata;
                    1:       m_act = {7'b0, toggle_q};
                    2:       m_act = {4'b0, fetch_pc};
                    default: m_act = {7'b0, fetch_req};
                endcase
                if (m_act !== m_e.val) begin
                    n_fail++;
                    $display("FAIL %s got %0h want %0h", m_e.name, m_act, m_e.val);
                end
            end
        end
    end

    task automatic chk(input int kind, input logic [1:0] sel, input logic [7:0] val, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = nm;
        obs_q.push_back(e);
        dbg_sel = sel;
        obs_en  = 1'b1;
        @(posedge clk); #1;
        obs_en  = 1'b0;
    endtask

    task automatic preload(input logic [1:0] sel, input logic [7:0] val);
        run       = 1'b0;
        dbg_sel   = sel;
        dbg_wdata = val;
        dbg_we    = 1'b1;
        @(posedge clk); #1;
        dbg_we    = 1'b0;
    endtask

    task automatic exec(input logic [7:0] ins, input logic [3:0] epc,
                        input logic bcf, input logic bbf, input logic buc, input logic tog,
                        input bit drop_run, input bit rst_wb);
        int n;
        run = 1'b1;
        #1;
        n = 0;
        while (!fetch_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!fetch_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_wait ins=%h got no fetch_req want fetch_req", ins);
            return;
        end
        exp_pc_q.push_back(epc);
        b_bcf = bcf; b_bbf = bbf; b_buc = buc; b_tog = tog;
        fetch_instr = ins;
        fetch_valid = 1'b1;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        if (drop_run) run = 1'b0;
        @(posedge clk); #1;
        if (rst_wb) begin
            rst_n = 1'b0;
            #1;
            b_bcf = 0; b_bbf = 0; b_buc = 0; b_tog = 0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            @(posedge clk); #1;
        end
        b_bcf = 0; b_bbf = 0; b_buc = 0; b_tog = 0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        run = 1'b1;
        @(posedge clk); #1;
        chk(3, 0, 8'h00, "rst_fetch_req");
        chk(2, 0, 8'h00, "rst_pc");
        chk(1, 0, 8'h00, "rst_toggle");
        chk(0, 0, 8'h00, "rst_r0");
        rst_n = 1'b1;
        #1;
        chk(3, 0, 8'h01, "first_fetch_req");

        preload(2'd0, 8'hF0);
        preload(2'd1, 8'h20);
        exec(8'h04, 4'h0, 0, 0, 0, 0, 0, 0);          // ADD r0 += r1
        chk(0, 0, 8'h10, "add_r0");
        chk(0, 1, 8'h20, "add_r1_kept");
        chk(2, 0, 8'h01, "add_pc");

        preload(2'd2, 8'h05);
        preload(2'd3, 8'h07);
        exec(8'h6C, 4'h1, 0, 0, 0, 0, 0, 0);          // SUB r2 -= r3
        chk(0, 2, 8'hFE, "sub_r2");
        chk(2, 0, 8'h02, "sub_pc");

        exec(8'hE8, 4'h2, 1, 0, 0, 0, 0, 0);          // bcf, carry still set
        chk(0, 2, 8'hFE, "bcf_taken_nowrite");
        chk(2, 0, 8'h0A, "bcf_taken_pc");

        exec(8'h34, 4'hA, 0, 0, 0, 0, 0, 0);          // ADD r3 += r1, clears carry
        chk(0, 3, 8'h27, "add_nocarry_r3");
        exec(8'hE8, 4'hB, 1, 0, 0, 0, 0, 0);
        chk(0, 2, 8'hFE, "bcf_fall_nowrite");
        chk(2, 0, 8'h0C, "bcf_fall_pc");

        exec(8'hCD, 4'hC, 0, 1, 0, 0, 0, 0);          // bbf, borrow set
        chk(2, 0, 8'h03, "bbf_taken_pc");
        chk(0, 0, 8'h10, "bbf_r0_kept");
        exec(8'hFC, 4'h3, 0, 0, 1, 0, 0, 0);          // buc
        chk(2, 0, 8'h0F, "buc_pc");

        exec(8'hF1, 4'hF, 0, 0, 0, 0, 0, 0);          // MOV r3 = r1 at pc 15
        chk(0, 3, 8'h20, "mov_r3");
        chk(2, 0, 8'h00, "pc_wrap");

        exec(8'h84, 4'h0, 0, 0, 0, 1, 0, 0);          // XOR r0 ^= r1, toggle
        chk(0, 0, 8'h30, "xor_r0");
        chk(1, 0, 8'h01, "toggle_1");
        for (int i = 0; i < 5; i++) chk(3, 0, 8'h01, "stall_fetch_req");
        chk(2, 0, 8'h01, "stall_pc");

        dbg_sel = 2'd2; dbg_wdata = 8'hAA; dbg_we = 1'b1;
        @(posedge clk); #1;
        dbg_we = 1'b0;
        chk(0, 2, 8'hFE, "dbg_we_run_ignored");

        exec(8'hA8, 4'h1, 0, 0, 0, 1, 0, 0);          // XOR r2 ^= r2, toggle
        chk(0, 2, 8'h00, "xor_self_r2");
        chk(1, 0, 8'h00, "toggle_0");
        exec(8'hD4, 4'h2, 0, 0, 1, 1, 0, 0);          // buc + toggle
        chk(2, 0, 8'h05, "buc_toggle_pc");
        chk(1, 0, 8'h01, "buc_toggle_t");
        chk(0, 1, 8'h20, "buc_r1_kept");

        preload(2'd1, 8'hF0);
        exec(8'h34, 4'h5, 0, 0, 0, 0, 0, 0);          // r3 = 0x20+0xF0, carry set
        chk(0, 3, 8'h10, "add_carry_r3");
        exec(8'h04, 4'h6, 0, 0, 0, 1, 0, 1);          // reset during WB
        chk(0, 0, 8'h00, "wbrst_r0");
        chk(0, 3, 8'h00, "wbrst_r3");
        chk(1, 0, 8'h00, "wbrst_toggle");
        chk(2, 0, 8'h00, "wbrst_pc");

        preload(2'd1, 8'h55);
        exec(8'hD4, 4'h0, 1, 1, 0, 0, 0, 0);          // flags cleared: falls through
        chk(0, 1, 8'h55, "wbrst_flags_nowrite");
        chk(2, 0, 8'h01, "wbrst_flags_pc");

        exec(8'h84, 4'h1, 0, 0, 0, 1, 1, 0);          // run dropped in EXEC
        chk(0, 0, 8'h55, "droprun_r0");
        chk(3, 0, 8'h00, "droprun_hold");
        chk(1, 0, 8'h01, "toggle_again_1");
        exec(8'h80, 4'h2, 0, 0, 0, 1, 0, 0);
        chk(1, 0, 8'h00, "toggle_again_0");
        chk(0, 0, 8'h00, "xor_r0_self");
        chk(2, 0, 8'h03, "final_pc");

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_pc_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", exp_pc_q.size(), obs_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
